// File: rtl/ccr_freeze_unit_if.sv
// Bundle of the CCR freeze unit's EX-side flag, interrupt and RTI signals.
// The master side drives the pipeline controls and the slave side is the CCR unit.
interface ccr_freeze_unit_if #(
    parameter int SAVE_DEPTH = 2
);
    localparam int DEPTH_W = $clog2(SAVE_DEPTH + 1);

    logic               stall;
    logic               flagWrEn;
    logic               zeroFlagIn;
    logic               carryFlagIn;
    logic               overFlowFlagIn;
    logic               negativeFlagIn;
    logic               intReq;
    logic               drainDone;
    logic               rtiReq;
    logic               intAck;
    logic [3:0]         ccrOut;
    logic [3:0]         freezedCCR;
    logic [DEPTH_W-1:0] saveDepth;
    logic [1:0]         ccrErr;

    modport master (
        output stall, flagWrEn, zeroFlagIn, carryFlagIn, overFlowFlagIn, negativeFlagIn,
               intReq, drainDone, rtiReq,
        input  intAck, ccrOut, freezedCCR, saveDepth, ccrErr
    );

    modport slave (
        input  stall, flagWrEn, zeroFlagIn, carryFlagIn, overFlowFlagIn, negativeFlagIn,
               intReq, drainDone, rtiReq,
        output intAck, ccrOut, freezedCCR, saveDepth, ccrErr
    );
endinterface

// File: rtl/ccr_freeze_unit.sv
// Condition-code register with an interrupt save stack; RTI pops the snapshot back into the CCR.
// Optional macro CCR_FLAG_FORWARD_EN bypasses incoming flags straight onto ccrOut.
module ccr_freeze_unit #(
    parameter int SAVE_DEPTH = 2
) (
    input logic             clk,
    input logic             rst_n,
    ccr_freeze_unit_if.slave bus
);
    localparam int DEPTH_W = $clog2(SAVE_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, SAVE, ACK} state_t;

    state_t             state;
    logic [3:0]         ccr;
    logic [3:0]         ccr_next;
    logic [3:0]         flags_in;
    logic [3:0]         stack_top;
    logic [3:0]         stack [SAVE_DEPTH];
    logic [DEPTH_W-1:0] depth;
    logic [1:0]         err;
    logic               pop;
    logic               empty;
    logic               full;

    assign flags_in = {bus.negativeFlagIn, bus.overFlowFlagIn, bus.carryFlagIn, bus.zeroFlagIn};
    assign empty    = (depth == '0);
    assign full     = (depth == DEPTH_W'(SAVE_DEPTH));
    assign pop      = (state == IDLE) && bus.rtiReq && !bus.stall;

    // Loop compare instead of stack[depth-1] keeps the index width equal to the array range.
    always_comb begin
        stack_top = '0;
        for (int unsigned i = 0; i < SAVE_DEPTH; i++) begin
            if (DEPTH_W'(i + 1) == depth) stack_top = stack[i];
        end
    end

    // stack_top is already zero when empty, giving the underflow restore value for free.
    always_comb begin
        ccr_next = ccr;
        if (pop)               ccr_next = stack_top;
        else if (bus.flagWrEn) ccr_next = flags_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ccr   <= '0;
            depth <= '0;
            err   <= '0;
            for (int unsigned i = 0; i < SAVE_DEPTH; i++) stack[i] <= '0;
        end else if (!bus.stall) begin
            ccr <= ccr_next;
            case (state)
                IDLE: begin
                    if (bus.rtiReq) begin
                        if (empty) err[0] <= 1'b1;
                        else       depth  <= depth - DEPTH_W'(1);
                    end else if (bus.intReq) begin
                        state <= SAVE;
                    end
                end
                SAVE: begin
                    if (bus.rtiReq) err[0] <= 1'b1;
                    if (bus.drainDone) begin
                        if (full) begin
                            err[1] <= 1'b1;
                        end else begin
                            for (int unsigned i = 0; i < SAVE_DEPTH; i++) begin
                                if (DEPTH_W'(i) == depth) stack[i] <= ccr_next;
                            end
                            depth <= depth + DEPTH_W'(1);
                        end
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (bus.rtiReq) err[0] <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CCR_FLAG_FORWARD_EN
    assign bus.ccrOut = pop ? stack_top : (bus.flagWrEn ? flags_in : ccr);
`else
    assign bus.ccrOut = ccr;
`endif

    assign bus.intAck     = (state == ACK) && !bus.stall;
    assign bus.freezedCCR = stack_top;
    assign bus.saveDepth  = depth;
    assign bus.ccrErr     = err;
endmodule

// File: tb/tb_ccr_freeze_unit.sv
// Self-checking bench for ccr_freeze_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based behavioural model.
module tb_ccr_freeze_unit;
    localparam int D       = 2;
    localparam int DEPTH_W = $clog2(D + 1);

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en   = 0;

    ccr_freeze_unit_if #(.SAVE_DEPTH(D)) bus ();

    ccr_freeze_unit #(.SAVE_DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: CCR value, snapshot queue, sticky errors and interrupt phase.
    typedef enum {M_RUN, M_WAIT_DRAIN, M_ACKING} mphase_t;
    mphase_t    m_phase;
    logic [3:0] m_ccr;
    logic [3:0] m_q [$];
    logic [1:0] m_err;

    function automatic logic [3:0] in_flags();
        return {bus.negativeFlagIn, bus.overFlowFlagIn, bus.carryFlagIn, bus.zeroFlagIn};
    endfunction

    function automatic logic [3:0] m_top();
        return (m_q.size() == 0) ? 4'b0 : m_q[m_q.size() - 1];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = M_RUN;
            m_ccr   = 4'b0;
            m_q.delete();
            m_err   = 2'b0;
        end else if (!bus.stall) begin
            if (m_phase == M_RUN && bus.rtiReq) begin
                if (m_q.size() == 0) begin
                    m_ccr    = 4'b0;
                    m_err[0] = 1'b1;
                end else begin
                    m_ccr = m_q.pop_back();
                end
            end else begin
                if (bus.flagWrEn) m_ccr = in_flags();
                if (m_phase != M_RUN && bus.rtiReq) m_err[0] = 1'b1;
                case (m_phase)
                    M_RUN:        if (bus.intReq) m_phase = M_WAIT_DRAIN;
                    M_WAIT_DRAIN: if (bus.drainDone) begin
                        if (m_q.size() < D) m_q.push_back(m_ccr);
                        else                m_err[1] = 1'b1;
                        m_phase = M_ACKING;
                    end
                    default:      m_phase = M_RUN;
                endcase
            end
        end
    end

    function automatic logic [3:0] exp_ccr_out();
`ifdef CCR_FLAG_FORWARD_EN
        if (m_phase == M_RUN && bus.rtiReq && !bus.stall) return m_top();
        if (bus.flagWrEn) return in_flags();
`endif
        return m_ccr;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ccrOut",     8'(bus.ccrOut),     8'(exp_ccr_out()));
            chk("freezedCCR", 8'(bus.freezedCCR), 8'(m_top()));
            chk("saveDepth",  8'(bus.saveDepth),  8'(m_q.size()));
            chk("ccrErr",     8'(bus.ccrErr),     8'(m_err));
            chk("intAck",     8'(bus.intAck),     8'(m_phase == M_ACKING && !bus.stall));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall = 0; bus.flagWrEn = 0; bus.rtiReq = 0;
        bus.zeroFlagIn = 0; bus.carryFlagIn = 0; bus.overFlowFlagIn = 0; bus.negativeFlagIn = 0;
    endtask

    task automatic write_flags(input logic [3:0] f);
        {bus.negativeFlagIn, bus.overFlowFlagIn, bus.carryFlagIn, bus.zeroFlagIn} = f;
        bus.flagWrEn = 1;
        tick();
        idle();
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle(); bus.intReq = 0; bus.drainDone = 0;
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    task automatic take_interrupt();
        bus.intReq = 1; bus.drainDone = 1;
        tick(); tick();
        chk("int_ack_pulse", 8'(bus.intAck), 8'd1);
        bus.intReq = 0; bus.drainDone = 0;
        tick();
    endtask

    bit got_ack;

    initial begin
        rst_n = 0;
        idle(); bus.intReq = 0; bus.drainDone = 0;
        do_reset();
        chk_en = 1;
        chk("rst_ccrOut", 8'(bus.ccrOut), 8'h0);
        chk("rst_intAck", 8'(bus.intAck), 8'h0);

        write_flags(4'b1001);
        chk("cap_ccrOut", 8'(bus.ccrOut), 8'h9);
        chk("cap_freezed", 8'(bus.freezedCCR), 8'h0);
        chk("cap_depth", 8'(bus.saveDepth), 8'h0);

        write_flags(4'b0110);
        bus.intReq = 1; bus.drainDone = 1;
        tick();
        chk("save_no_ack", 8'(bus.intAck), 8'h0);
        tick();
        chk("ack_latency2", 8'(bus.intAck), 8'h1);
        chk("push_freezed", 8'(bus.freezedCCR), 8'h6);
        chk("push_depth", 8'(bus.saveDepth), 8'h1);
        bus.intReq = 0; bus.drainDone = 0;
        tick();
        chk("ack_one_cycle", 8'(bus.intAck), 8'h0);

        write_flags(4'b0001);
        bus.rtiReq = 1;
        tick();
        bus.rtiReq = 0;
        chk("rti_restore", 8'(bus.ccrOut), 8'h6);
        chk("rti_depth", 8'(bus.saveDepth), 8'h0);
        chk("rti_freezed", 8'(bus.freezedCCR), 8'h0);

        for (int i = 0; i < 3; i++) take_interrupt();
        chk("nest_depth", 8'(bus.saveDepth), 8'h2);
        chk("nest_err", 8'(bus.ccrErr), 8'h2);
        for (int i = 0; i < 3; i++) begin
            bus.rtiReq = 1; tick(); bus.rtiReq = 0; tick();
        end
        chk("under_err", 8'(bus.ccrErr), 8'h3);
        chk("under_ccr", 8'(bus.ccrOut), 8'h0);

        do_reset();
        write_flags(4'b1010);
        take_interrupt();
        write_flags(4'b0011);
        bus.intReq = 1; bus.rtiReq = 1; bus.drainDone = 1;
        tick();
        bus.rtiReq = 0;
        chk("rti_int_pop", 8'(bus.ccrOut), 8'hA);
        chk("rti_int_depth0", 8'(bus.saveDepth), 8'h0);
        tick(); tick();
        chk("rti_int_ack", 8'(bus.intAck), 8'h1);
        chk("rti_int_push", 8'(bus.freezedCCR), 8'hA);
        chk("rti_int_err", 8'(bus.ccrErr), 8'h0);
        bus.intReq = 0;
        tick();

        bus.intReq = 1; bus.drainDone = 1;
        tick();
        bus.stall = 1;
        repeat (3) tick();
        chk("stall_no_ack", 8'(bus.intAck), 8'h0);
        chk("stall_depth", 8'(bus.saveDepth), 8'h1);
        bus.stall = 0;
        tick();
        chk("unstall_ack", 8'(bus.intAck), 8'h1);
        chk("unstall_depth", 8'(bus.saveDepth), 8'h2);
        bus.intReq = 0; bus.drainDone = 0;
        tick();

        bus.intReq = 1; bus.drainDone = 0;
        tick();
        rst_n = 0;
        #2;
        chk("midrst_ccr", 8'(bus.ccrOut), 8'h0);
        chk("midrst_depth", 8'(bus.saveDepth), 8'h0);
        chk("midrst_err", 8'(bus.ccrErr), 8'h0);
        chk("midrst_ack", 8'(bus.intAck), 8'h0);
        bus.intReq = 0;
        rst_n = 1;
        bus.drainDone = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("postrst_no_ack", 8'(bus.intAck), 8'h0);
        end
        bus.drainDone = 0;

        got_ack = 0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            rst_n = ($urandom_range(0, 599) != 0);
            if (got_ack) bus.intReq = 0;
            else if (!bus.intReq && $urandom_range(0, 7) == 0) bus.intReq = 1;
            bus.stall     = ($urandom_range(0, 6) == 0);
            bus.drainDone = ($urandom_range(0, 2) == 0);
            bus.rtiReq    = ($urandom_range(0, 9) == 0);
            bus.flagWrEn  = $urandom_range(0, 1);
            {bus.negativeFlagIn, bus.overFlowFlagIn, bus.carryFlagIn, bus.zeroFlagIn} = 4'($urandom);
            #1;
            got_ack = bus.intAck;
        end

        idle();
        tick();
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
